pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline sequencing controller for the 5-stage MIPS core with CP0. Drives write-enable and flush for the PC and the F/D, D/E, E/M and M/W pipeline registers. Tracks the multi-cycle MDU with an internal latency counter and state machine, and stalls D-stage MDU consumers while the MDU is busy. Arbitrates precedence between exception/interrupt requests, stalls and eret.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu.
DIV_CYCLES, 10, busy cycles for div/divu.
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
d_hz_stall  in  1  raw data-hazard stall from the hazard comparator (combinational)
d_mdu_use  in  1  D-stage instruction is mfhi/mflo/mthi/mtlo/mult/multu/div/divu
e_mdu_start  in  1  E-stage instruction starts the MDU this cycle
e_mdu_is_div  in  1  qualifies e_mdu_start: 1 = div/divu, 0 = mult/multu
d_eret  in  1  eret is in D stage
int_req  in  1  exception/interrupt request from CP0 (M stage)
pc_wren  out  1  PC update enable
fd_wren  out  1  F/D enable
de_wren, em_wren, mw_wren  out  1 each  stage enables
fd_flush, de_flush, em_flush, mw_flush  out  1 each  stage flushes
req  out  1  broadcast request; registers load 0x0000_4180 / bubble
mdu_busy  out  1  MDU computing
mdu_done  out  1  one-cycle pulse in the last busy cycle

Behaviour:
- FSM states: IDLE, MULT, DIV. Counter cnt[CNT_W-1:0].
- Reset: state=IDLE, cnt=0, mdu_busy=0, mdu_done=0, perf counters=0.
- IDLE:
  - e_mdu_start & ~req: next state MULT or DIV; cnt loads MULT_CYCLES or DIV_CYCLES.
  - mdu_busy rises the cycle after start.
- MULT/DIV: cnt decrements each cycle.
  - mdu_done=1 while cnt==1.
  - At cnt==1, next state is IDLE.
  - Busy lasts exactly N cycles.
- A new e_mdu_start while busy is impossible by construction (D is stalled); the controller ignores it.
- mdu_stall = d_mdu_use & (e_mdu_start | mdu_busy).
- stall = (d_hz_stall | mdu_stall) & ~req.
- Priority, highest first:
  - reset: all enables 1, all flushes 1, req=0.
  - req (=int_req): req=1; all enables 1; all flushes 0. Registers apply req themselves: PC/stage registers load 0x4180 and a bubble.
  - stall: pc_wren=fd_wren=0; de_flush=1 to inject a bubble into E; other enables 1.
  - d_eret & ~stall: fd_flush=1 to kill the eret delay-slot fetch.
  - Otherwise all enables 1, flushes 0.
- Simultaneous req & e_mdu_start: the start is cancelled; the FSM stays IDLE.
- req while busy: the in-flight operation continues to completion (HI/LO committed per MIPS); the FSM is unaffected.
- Reset mid-operation: the FSM returns to IDLE immediately on the next edge, and mdu_busy drops.
- All control outputs except mdu_busy/mdu_done are combinational; mdu_busy and mdu_done are derived from registered state only.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: adds outputs perf_stall_cnt[31:0] and perf_mdu_cnt[31:0], both cleared by reset.
  - perf_stall_cnt increments every cycle stall=1.
  - perf_mdu_cnt increments every cycle mdu_busy=1.
  - Both wrap at 2^32 to 0.
- Undefined: ports and counters absent; other behaviour identical.

Decomposition:
- Shared package/header def.v holds:
  - FSM state encodings (`PC_IDLE`, `PC_MULT`, `PC_DIV`).
  - The exception vector 32'h0000_4180.
  - Default MULT_CYCLES/DIV_CYCLES constants.
- One natural sub-module: pipe_mdu_timer, holding the FSM, counter, busy and done logic. The top level holds the priority/stall combinational logic.

Test Plan:
- Reset then idle: all enables=1, flushes=0, req=0, mdu_busy=0 -> verify steady state over 5 cycles.
- e_mdu_start=1, e_mdu_is_div=0 at cycle 0 -> mdu_busy=1 cycles 1-5, mdu_done=1 at cycle 5 only, busy=0 at cycle 6.
- div start with d_mdu_use=1 held -> pc_wren=fd_wren=0 and de_flush=1 from cycle 0 through cycle 10; released at cycle 11.
- int_req=1 together with e_mdu_start and d_hz_stall -> req=1, all enables=1, no flush, FSM stays IDLE.
- int_req during MULT cycle 3 -> busy persists; done still pulses at cycle 5.
- reset asserted at DIV cycle 4 -> mdu_busy=0 next cycle; with PIPE_CTRL_PERF_EN, both perf counters read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: MDU FSM encodings, exception vector,
// default MDU latencies.
package pipe_ctrl_pkg;

   localparam logic [1:0] PC_IDLE = 2'd0;
   localparam logic [1:0] PC_MULT = 2'd1;
   localparam logic [1:0] PC_DIV  = 2'd2;

   localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/pipe_mdu_timer.sv
// MDU latency tracker: IDLE/MULT/DIV state machine with a down-counter; busy and done
// come from registered state only.
module pipe_mdu_timer
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int unsigned CNT_W       = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   input  logic cancel,
   output logic busy,
   output logic done
);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (reset) begin
         state_d = PC_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            PC_IDLE: begin
               // A start coinciding with an exception request never launches.
               if (start && !cancel) begin
                  state_d = is_div ? PC_DIV : PC_MULT;
                  cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
               end
            end
            PC_MULT, PC_DIV: begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) state_d = PC_IDLE;
            end
            default: begin
               state_d = PC_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
   end

   assign busy = (state_q != PC_IDLE);
   assign done = busy && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes with reset > req > stall > eret
// precedence. Optional PIPE_CTRL_PERF_EN adds stall and MDU-busy cycle counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int unsigned CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        d_hz_stall,
   input  logic        d_mdu_use,
   input  logic        e_mdu_start,
   input  logic        e_mdu_is_div,
   input  logic        d_eret,
   input  logic        int_req,
   output logic        pc_wren,
   output logic        fd_wren,
   output logic        de_wren,
   output logic        em_wren,
   output logic        mw_wren,
   output logic        fd_flush,
   output logic        de_flush,
   output logic        em_flush,
   output logic        mw_flush,
   output logic        req,
   output logic        mdu_busy,
   output logic        mdu_done
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_mdu_cnt
`endif
);

   logic mdu_stall;
   logic stall;

   pipe_mdu_timer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_mdu_timer (
      .clk    (clk),
      .reset  (reset),
      .start  (e_mdu_start),
      .is_div (e_mdu_is_div),
      .cancel (int_req),
      .busy   (mdu_busy),
      .done   (mdu_done)
   );

   assign mdu_stall = d_mdu_use & (e_mdu_start | mdu_busy);
   assign stall     = (d_hz_stall | mdu_stall) & ~int_req;

   always_comb begin
      pc_wren  = 1'b1;
      fd_wren  = 1'b1;
      de_wren  = 1'b1;
      em_wren  = 1'b1;
      mw_wren  = 1'b1;
      fd_flush = 1'b0;
      de_flush = 1'b0;
      em_flush = 1'b0;
      mw_flush = 1'b0;
      req      = 1'b0;
      if (reset) begin
         fd_flush = 1'b1;
         de_flush = 1'b1;
         em_flush = 1'b1;
         mw_flush = 1'b1;
      end else if (int_req) begin
         // Registers load the exception vector / bubble themselves on req.
         req = 1'b1;
      end else if (stall) begin
         pc_wren  = 1'b0;
         fd_wren  = 1'b0;
         de_flush = 1'b1;
      end else if (d_eret) begin
         fd_flush = 1'b1;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] mdu_cnt_q, mdu_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      mdu_cnt_d   = mdu_cnt_q;
      if (reset) begin
         stall_cnt_d = '0;
         mdu_cnt_d   = '0;
      end else begin
         if (stall)    stall_cnt_d = stall_cnt_q + 32'd1;
         if (mdu_busy) mdu_cnt_d   = mdu_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      stall_cnt_q <= stall_cnt_d;
      mdu_cnt_q   <= mdu_cnt_d;
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_mdu_cnt   = mdu_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: per-cycle comparison against a cycle-count model of the MDU and
// the control precedence rules, plus directed scenarios with literal expectations.
module tb_pipe_ctrl;

   logic clk = 1'b0;
   logic reset, d_hz_stall, d_mdu_use, e_mdu_start, e_mdu_is_div, d_eret, int_req;
   logic pc_wren, fd_wren, de_wren, em_wren, mw_wren;
   logic fd_flush, de_flush, em_flush, mw_flush;
   logic req, mdu_busy, mdu_done;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_cnt, perf_mdu_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .d_hz_stall   (d_hz_stall),
      .d_mdu_use    (d_mdu_use),
      .e_mdu_start  (e_mdu_start),
      .e_mdu_is_div (e_mdu_is_div),
      .d_eret       (d_eret),
      .int_req      (int_req),
      .pc_wren      (pc_wren),
      .fd_wren      (fd_wren),
      .de_wren      (de_wren),
      .em_wren      (em_wren),
      .mw_wren      (mw_wren),
      .fd_flush     (fd_flush),
      .de_flush     (de_flush),
      .em_flush     (em_flush),
      .mw_flush     (mw_flush),
      .req          (req),
      .mdu_busy     (mdu_busy),
      .mdu_done     (mdu_done)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_mdu_cnt   (perf_mdu_cnt)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: remaining busy cycles of the MDU operation (0 = idle).
   int          busy_left = 0;
   bit          model_ok  = 0;
   logic [31:0] m_stall_cnt = 0;
   logic [31:0] m_mdu_cnt   = 0;

   initial begin
      forever begin
         int  nxt;
         bit  m_stall, m_busy;
         logic [9:0] exp_en_fl;
         @(negedge clk);
         m_busy  = (busy_left > 0);
         m_stall = (d_hz_stall | (d_mdu_use & (e_mdu_start | m_busy))) & ~int_req;
         // {pc,fd,de,em,mw enables, fd,de,em,mw flushes, req}
         if (reset)        exp_en_fl = 10'b11111_1111_0;
         else if (int_req) exp_en_fl = 10'b11111_0000_1;
         else if (m_stall) exp_en_fl = 10'b00111_0100_0;
         else if (d_eret)  exp_en_fl = 10'b11111_1000_0;
         else              exp_en_fl = 10'b11111_0000_0;
         check("ctrl", {22'b0, pc_wren, fd_wren, de_wren, em_wren, mw_wren,
                        fd_flush, de_flush, em_flush, mw_flush, req}, {22'b0, exp_en_fl});
         if (model_ok) begin
            check("mdu_busy", {31'b0, mdu_busy}, {31'b0, m_busy});
            check("mdu_done", {31'b0, mdu_done}, {31'b0, busy_left == 1});
`ifdef PIPE_CTRL_PERF_EN
            check("perf_stall", perf_stall_cnt, m_stall_cnt);
            check("perf_mdu", perf_mdu_cnt, m_mdu_cnt);
`endif
         end
         if (reset)            nxt = 0;
         else if (m_busy)      nxt = busy_left - 1;
         else if (e_mdu_start && !int_req) nxt = e_mdu_is_div ? 10 : 5;
         else                  nxt = 0;
         @(posedge clk);
         if (reset) begin
            model_ok    = 1;
            m_stall_cnt = 0;
            m_mdu_cnt   = 0;
         end else begin
            if (m_stall) m_stall_cnt = m_stall_cnt + 1;
            if (m_busy)  m_mdu_cnt   = m_mdu_cnt + 1;
         end
         busy_left = nxt;
      end
   end

   initial begin
      reset = 1'b1; d_hz_stall = 0; d_mdu_use = 0; e_mdu_start = 0;
      e_mdu_is_div = 0; d_eret = 0; int_req = 0;
      @(negedge clk);
      check("reset_flush", {28'b0, fd_flush, de_flush, em_flush, mw_flush}, 32'hf);
      check("reset_req", {31'b0, req}, 32'h0);
      tick(); tick();
      reset = 1'b0;

      // Idle steady state.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_en", {27'b0, pc_wren, fd_wren, de_wren, em_wren, mw_wren}, 32'h1f);
         check("idle_busy", {31'b0, mdu_busy}, 32'h0);
         tick();
      end

      // mult: busy cycles 1..5, done at 5.
      e_mdu_start = 1; e_mdu_is_div = 0;
      tick();
      e_mdu_start = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         check("mult_busy", {31'b0, mdu_busy}, (c <= 5) ? 32'h1 : 32'h0);
         check("mult_done", {31'b0, mdu_done}, (c == 5) ? 32'h1 : 32'h0);
         tick();
      end

      // div with D-stage MDU consumer held: stalled cycles 0..10.
      e_mdu_start = 1; e_mdu_is_div = 1; d_mdu_use = 1;
      for (int c = 0; c <= 11; c++) begin
         @(negedge clk);
         check("div_pc_wren", {31'b0, pc_wren}, (c >= 11) ? 32'h1 : 32'h0);
         check("div_de_flush", {31'b0, de_flush}, (c < 11) ? 32'h1 : 32'h0);
         tick();
         e_mdu_start = 0;
      end
      d_mdu_use = 0; e_mdu_is_div = 0;

      // req with start and hazard: req wins, start cancelled.
      int_req = 1; e_mdu_start = 1; d_hz_stall = 1;
      @(negedge clk);
      check("req_out", {31'b0, req}, 32'h1);
      check("req_en", {27'b0, pc_wren, fd_wren, de_wren, em_wren, mw_wren}, 32'h1f);
      check("req_flush", {28'b0, fd_flush, de_flush, em_flush, mw_flush}, 32'h0);
      tick();
      int_req = 0; e_mdu_start = 0; d_hz_stall = 0;
      @(negedge clk);
      check("req_cancel_busy", {31'b0, mdu_busy}, 32'h0);
      tick();

      // eret without and with a hazard stall.
      d_eret = 1;
      @(negedge clk);
      check("eret_fd_flush", {31'b0, fd_flush}, 32'h1);
      tick();
      d_hz_stall = 1;
      @(negedge clk);
      check("eret_stall_fd_flush", {31'b0, fd_flush}, 32'h0);
      check("eret_stall_de_flush", {31'b0, de_flush}, 32'h1);
      tick();
      d_eret = 0; d_hz_stall = 0;

      // req during mult cycle 3 leaves the operation running.
      e_mdu_start = 1;
      tick();
      e_mdu_start = 0;
      for (int c = 1; c <= 6; c++) begin
         int_req = (c == 3);
         @(negedge clk);
         check("mreq_busy", {31'b0, mdu_busy}, (c <= 5) ? 32'h1 : 32'h0);
         check("mreq_done", {31'b0, mdu_done}, (c == 5) ? 32'h1 : 32'h0);
         tick();
      end
      int_req = 0;

      // Reset during div cycle 4.
      e_mdu_start = 1; e_mdu_is_div = 1;
      tick();
      e_mdu_start = 0;
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) reset = 1;
         @(negedge clk);
         check("rdiv_busy", {31'b0, mdu_busy}, 32'h1);
         tick();
      end
      @(negedge clk);
      check("rdiv_busy_after", {31'b0, mdu_busy}, 32'h0);
      check("rdiv_done_after", {31'b0, mdu_done}, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
      check("rdiv_perf_stall", perf_stall_cnt, 32'h0);
      check("rdiv_perf_mdu", perf_mdu_cnt, 32'h0);
`endif
      tick();
      reset = 0; e_mdu_is_div = 0;
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
